// File: rtl/slot_round_ctrl.sv
// Round sequencer for a three-reel slot: credit bookkeeping, timed reel stops and payout.
// Define SKILL_STOP_EN to let a lever edge during a spin stop the current reel early.
module slot_round_ctrl #(
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned STOP_GAP    = 16,
    parameter int unsigned MAX_CREDIT  = 255,
    parameter int unsigned PAY_PAIR    = 1,
    parameter int unsigned PAY_TRIPLE  = 5,
    parameter int unsigned PAY_JACKPOT = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin,
    input  logic                lever,
    input  logic [8:0]          reel_val,
    output logic [2:0]          reel_run,
    output logic [2:0]          sym0,
    output logic [2:0]          sym1,
    output logic [2:0]          sym2,
    output logic [CREDIT_W-1:0] credits,
    output logic [CREDIT_W-1:0] win_amt,
    output logic                win_valid,
    output logic                busy,
    output logic                no_credit
);

    localparam int unsigned      CNT_W    = (STOP_GAP > 1) ? $clog2(STOP_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STOP_GAP - 1);
    localparam logic [CREDIT_W:0] MAX_C   = (CREDIT_W + 1)'(MAX_CREDIT);

    typedef enum logic [2:0] {
        IDLE,
        SPIN0,
        SPIN1,
        SPIN2,
        EVAL,
        PAY
    } state_e;

    state_e              state_q;
    logic                lever_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2:0]          reel_run_q;
    logic [2:0]          sym0_q, sym1_q, sym2_q;
    logic [CREDIT_W-1:0] credits_q;
    logic [CREDIT_W-1:0] win_q;
    logic                win_valid_q;
    logic                busy_q;
    logic                no_credit_q;

    logic                lever_edge;
    logic                stop_d;
    logic [CREDIT_W:0]   coin_sum_d;
    logic [CREDIT_W-1:0] cred_coin_d;
    logic [CREDIT_W-1:0] cred_start_d;
    logic [CREDIT_W:0]   pay_sum_d;
    logic [CREDIT_W-1:0] cred_pay_d;
    logic [CREDIT_W-1:0] payout_d;

    assign lever_edge = lever & ~lever_q;

`ifdef SKILL_STOP_EN
    // Either event stops exactly one reel; both in one cycle still count once.
    assign stop_d = (cnt_q == CNT_LAST) || lever_edge;
`else
    assign stop_d = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        coin_sum_d  = {1'b0, credits_q} + (CREDIT_W + 1)'(coin);
        cred_coin_d = (coin_sum_d > MAX_C) ? MAX_C[CREDIT_W-1:0] : coin_sum_d[CREDIT_W-1:0];
        // Only taken with credits_q >= 1, so neither underflow nor exceeding the ceiling.
        cred_start_d = credits_q - CREDIT_W'(1) + CREDIT_W'(coin);
        pay_sum_d  = {1'b0, credits_q} + {1'b0, win_q} + (CREDIT_W + 1)'(coin);
        cred_pay_d = (pay_sum_d > MAX_C) ? MAX_C[CREDIT_W-1:0] : pay_sum_d[CREDIT_W-1:0];
    end

    always_comb begin
        payout_d = '0;
        if ((sym0_q == sym1_q) && (sym1_q == sym2_q)) begin
            payout_d = (sym0_q == 3'b111) ? CREDIT_W'(PAY_JACKPOT) : CREDIT_W'(PAY_TRIPLE);
        end else if ((sym0_q == sym1_q) || (sym1_q == sym2_q) || (sym0_q == sym2_q)) begin
            payout_d = CREDIT_W'(PAY_PAIR);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lever_q     <= 1'b0;
            cnt_q       <= '0;
            reel_run_q  <= '0;
            sym0_q      <= '0;
            sym1_q      <= '0;
            sym2_q      <= '0;
            credits_q   <= '0;
            win_q       <= '0;
            win_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            no_credit_q <= 1'b0;
        end else begin
            lever_q     <= lever;
            win_valid_q <= 1'b0;
            no_credit_q <= 1'b0;
            credits_q   <= cred_coin_d;
            case (state_q)
                IDLE: begin
                    if (lever_edge) begin
                        if (credits_q != '0) begin
                            credits_q  <= cred_start_d;
                            reel_run_q <= 3'b111;
                            cnt_q      <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= SPIN0;
                        end else begin
                            no_credit_q <= 1'b1;
                        end
                    end
                end
                SPIN0: begin
                    if (stop_d) begin
                        sym0_q        <= reel_val[2:0];
                        reel_run_q[0] <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= SPIN1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SPIN1: begin
                    if (stop_d) begin
                        sym1_q        <= reel_val[5:3];
                        reel_run_q[1] <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= SPIN2;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                SPIN2: begin
                    if (stop_d) begin
                        sym2_q        <= reel_val[8:6];
                        reel_run_q[2] <= 1'b0;
                        cnt_q         <= '0;
                        state_q       <= EVAL;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                EVAL: begin
                    win_q   <= payout_d;
                    state_q <= PAY;
                end
                PAY: begin
                    credits_q   <= cred_pay_d;
                    win_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign reel_run  = reel_run_q;
    assign sym0      = sym0_q;
    assign sym1      = sym1_q;
    assign sym2      = sym2_q;
    assign credits   = credits_q;
    assign win_amt   = win_q;
    assign win_valid = win_valid_q;
    assign busy      = busy_q;
    assign no_credit = no_credit_q;

endmodule

// File: tb/tb_slot_round_ctrl.sv
// Self-checking bench for slot_round_ctrl: fixed payout table, hand-written corner
// sequences and randomized rounds against a round-level credit/payout model.
module tb_slot_round_ctrl;

    localparam int G    = 16;
    localparam int MAXC = 255;

    logic       clk = 1'b0;
    logic       reset, coin, lever;
    logic [8:0] reel_val;
    logic [2:0] reel_run, sym0, sym1, sym2;
    logic [7:0] credits, win_amt;
    logic       win_valid, busy, no_credit;

    int total = 0;
    int bad   = 0;
    int m_credits = 0;

    always #5 clk = ~clk;

    slot_round_ctrl #(
        .CREDIT_W(8), .STOP_GAP(G), .MAX_CREDIT(MAXC),
        .PAY_PAIR(1), .PAY_TRIPLE(5), .PAY_JACKPOT(20)
    ) dut (
        .clk(clk), .reset(reset), .coin(coin), .lever(lever), .reel_val(reel_val),
        .reel_run(reel_run), .sym0(sym0), .sym1(sym1), .sym2(sym2),
        .credits(credits), .win_amt(win_amt), .win_valid(win_valid),
        .busy(busy), .no_credit(no_credit)
    );

    typedef struct {
        logic [8:0] rv;
        int         exp_win;
        int         exp_cred;
    } vec_t;
    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic int payout(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        if (a == b && b == c) return (a == 3'd7) ? 20 : 5;
        if (a == b || b == c || a == c) return 1;
        return 0;
    endfunction

    function automatic logic rbit(input bit en);
        return en ? 1'($urandom_range(0, 1)) : 1'b0;
    endfunction

    task automatic do_reset();
        reset = 1'b1; coin = 1'b0; lever = 1'b0; reel_val = '0;
        step(); step();
        reset = 1'b0;
        m_credits = 0;
    endtask

    task automatic idle_cycle(input logic c);
        coin = c;
        step();
        m_credits = sat(m_credits + int'(c));
        check("idle_credits", credits, m_credits);
        coin = 1'b0;
    endtask

    // One full round from a clean IDLE (lever low last cycle, model credits >= 1).
    task automatic run_round(input bit rand_reels, input logic [8:0] fixed,
                             input bit rand_coin, input bit coin_in_pay);
        logic [2:0] s[3];
        logic [8:0] rv;
        logic       cn;
        int         w;
        lever = 1'b1;
        cn = rbit(rand_coin); coin = cn;
        reel_val = rand_reels ? 9'($urandom) : fixed;
        step();
        m_credits = m_credits - 1 + int'(cn);
        check("start_run", reel_run, 3'b111);
        check("start_busy", busy, 1'b1);
        check("start_credits", credits, m_credits);
        lever = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int t = 1; t <= G; t++) begin
`ifndef SKILL_STOP_EN
                lever = rbit(rand_coin);
`endif
                cn = rbit(rand_coin); coin = cn;
                rv = rand_reels ? 9'($urandom) : fixed;
                reel_val = rv;
                step();
                m_credits = sat(m_credits + int'(cn));
                if (t == G) begin
                    s[k] = rv[3*k +: 3];
                    check("stop_run", reel_run, (7 << (k + 1)) & 7);
                    case (k)
                        0: check("sym0", sym0, s[0]);
                        1: check("sym1", sym1, s[1]);
                        default: check("sym2", sym2, s[2]);
                    endcase
                end else begin
                    check("spin_run", reel_run, (7 << k) & 7);
                end
            end
        end
        lever = 1'b0;
        cn = rbit(rand_coin); coin = cn;
        step();
        m_credits = sat(m_credits + int'(cn));
        w = payout(s[0], s[1], s[2]);
        check("eval_win", win_amt, w);
        check("eval_valid", win_valid, 1'b0);
        check("eval_busy", busy, 1'b1);
        cn = coin_in_pay ? 1'b1 : rbit(rand_coin); coin = cn;
        step();
        m_credits = sat(m_credits + w + int'(cn));
        check("pay_credits", credits, m_credits);
        check("pay_valid", win_valid, 1'b1);
        check("pay_busy", busy, 1'b0);
        coin = 1'b0;
        step();
        check("valid_pulse_end", win_valid, 1'b0);
    endtask

    initial begin
        int starts;
        logic prev_busy;

        tbl[0] = '{ {3'd5, 3'd3, 3'd3}, 1, 2 };
        tbl[1] = '{ {3'd4, 3'd2, 3'd1}, 0, 1 };
        tbl[2] = '{ {3'd7, 3'd7, 3'd7}, 20, 20 };
        tbl[3] = '{ {3'd4, 3'd4, 3'd4}, 5, 24 };
        tbl[4] = '{ {3'd5, 3'd6, 3'd5}, 1, 24 };
        tbl[5] = '{ {3'd1, 3'd1, 3'd7}, 1, 24 };
        tbl[6] = '{ {3'd0, 3'd0, 3'd0}, 5, 28 };
        tbl[7] = '{ {3'd0, 3'd7, 3'd7}, 1, 28 };
        tbl[8] = '{ {3'd2, 3'd1, 3'd0}, 0, 27 };

        do_reset();
        check("rst_credits", credits, 0);
        check("rst_run", reel_run, 0);
        check("rst_syms", {sym2, sym1, sym0}, 0);
        check("rst_win", win_amt, 0);
        check("rst_valid", win_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_nocredit", no_credit, 0);

        // Lever with no credits: rejected with a single pulse.
        lever = 1'b1;
        step();
        check("nc_pulse", no_credit, 1'b1);
        check("nc_run", reel_run, 0);
        check("nc_busy", busy, 0);
        step();
        check("nc_pulse_end", no_credit, 1'b0);
        check("nc_hold_busy", busy, 0);
        lever = 1'b0;
        step();

        for (int i = 0; i < 3; i++) idle_cycle(1'b1);
        check("coins3", credits, 3);
        check("coins3_busy", busy, 0);

        do_reset();
        idle_cycle(1'b1);
        run_round(1'b0, 9'b111_111_111, 1'b0, 1'b0);
        check("jackpot_credits", credits, 20);

        // Payout table, starting from two credits.
        do_reset();
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        for (int i = 0; i < 9; i++) begin
            run_round(1'b0, tbl[i].rv, 1'b0, 1'b0);
            check("tbl_win", win_amt, tbl[i].exp_win);
            check("tbl_credits", credits, tbl[i].exp_cred);
        end

        // Held lever starts exactly one round.
        reel_val = {3'd2, 3'd1, 3'd0};
        lever = 1'b1;
        starts = 0;
        prev_busy = busy;
        for (int i = 0; i < 100; i++) begin
            step();
            if (busy && !prev_busy) starts++;
            prev_busy = busy;
        end
        check("hold_starts", starts, 1);
        check("hold_credits", credits, 26);
        check("hold_busy", busy, 0);
        lever = 1'b0;
        m_credits = 26;
        step();

        // Reset in SPIN1 aborts without refund.
        lever = 1'b1;
        step();
        lever = 1'b0;
        for (int i = 0; i < G + 3; i++) step();
        check("spin1_run", reel_run, 3'b110);
        reset = 1'b1;
        step();
        check("abort_run", reel_run, 0);
        check("abort_busy", busy, 0);
        check("abort_credits", credits, 0);
        reset = 1'b0;
        m_credits = 0;
        step();
        check("abort_idle_busy", busy, 0);

        // Saturation at the credit ceiling.
        for (int i = 0; i < 250; i++) idle_cycle(1'b1);
        check("cred250", credits, 250);
        run_round(1'b0, 9'b111_111_111, 1'b0, 1'b1);
        check("sat_pay", credits, 255);
        idle_cycle(1'b1);
        check("sat_coin", credits, 255);

        // Randomized rounds with coins arriving at arbitrary times.
        do_reset();
        for (int i = 0; i < 5; i++) idle_cycle(1'b1);
        for (int r = 0; r < 20; r++) begin
            int gap;
            gap = $urandom_range(0, 5);
            for (int i = 0; i < gap; i++) idle_cycle(rbit(1'b1));
            if (m_credits == 0) idle_cycle(1'b1);
            run_round(1'b1, '0, 1'b1, 1'b0);
        end

`ifdef SKILL_STOP_EN
        begin
            int waited;
            if (m_credits == 0) idle_cycle(1'b1);
            reel_val = '0;
            lever = 1'b1;
            step();
            lever = 1'b0;
            step();
            step();
            lever = 1'b1;
            reel_val = 9'b000_000_101;
            step();
            check("skill_run", reel_run, 3'b110);
            check("skill_sym0", sym0, 3'd5);
            lever = 1'b0;
            waited = 0;
            while (busy && waited < 200) begin
                step();
                waited++;
            end
            check("skill_done_busy", busy, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
